// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame controller.
//   Accepts a parallel word over DATA_VALID/TX_READY, latches it together with
//   its parity settings, and sequences an external bit serializer to build
//   START / DATA (LSB first) / optional PARITY / STOP bits on TX_OUT.
//   CLK is the baud clock: one line bit per cycle.
// Ports:
//   CLK, RST              baud clock, asynchronous active-high reset
//   P_DATA, DATA_VALID    word to send and its send request
//   PAR_EN, PAR_TYP       parity enable and type (0 even, 1 odd), sampled on accept
//   ser_done, ser_data    serializer last-bit flag and serial bit
//   ser_en, ser_p_data    serializer enable and latched word
//   TX_OUT                UART line, idle high
//   TX_READY, BUSY        can accept this cycle / frame in progress
//   SEQ_ERR               one-cycle pulse on serializer bit-count mismatch
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  TX_OUT,
    output logic                  TX_READY,
    output logic                  BUSY,
    output logic                  SEQ_ERR
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_reg;
    logic                  par_en_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic                  last_stop;
    logic                  accept;

    assign last_stop  = (stop_cnt == LAST_STOP);
    assign TX_READY   = (state == IDLE) || ((state == STOP) && last_stop);
    assign accept     = DATA_VALID && TX_READY;
    assign BUSY       = (state != IDLE);
    assign ser_p_data = data_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            data_reg   <= '0;
            par_reg    <= 1'b0;
            par_en_reg <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            SEQ_ERR    <= 1'b0;
        end else begin
            SEQ_ERR <= 1'b0;
            // Accept only happens in IDLE or the last STOP cycle, so data_reg
            // stays stable for the whole START..DATA window.
            if (accept) begin
                data_reg   <= P_DATA;
                par_reg    <= (^P_DATA) ^ PAR_TYP;
                par_en_reg <= PAR_EN;
            end
            case (state)
                IDLE: begin
                    if (accept) state <= START;
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
                DATA: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        // Exit on our own count; ser_done is only cross-checked.
                        SEQ_ERR  <= ~ser_done;
                        state    <= par_en_reg ? PARITY : STOP;
                        stop_cnt <= 1'b0;
                    end else begin
                        SEQ_ERR <= ser_done;
                    end
                end
                PARITY: begin
                    state    <= STOP;
                    stop_cnt <= 1'b0;
                end
                STOP: begin
                    if (last_stop) state <= accept ? START : IDLE;
                    else           stop_cnt <= stop_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line and serializer enable decode from registered state only.
    always_comb begin
        TX_OUT = 1'b1;
        ser_en = 1'b0;
        case (state)
            START: begin
                TX_OUT = 1'b0;
                ser_en = 1'b1;
            end
            DATA: begin
                TX_OUT = ser_data;
                ser_en = ~ser_done;
            end
            PARITY: TX_OUT = par_reg;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl.
//   u_dut1 uses STOP_BITS=1, u_dut2 uses STOP_BITS=2. Each has a small
//   behavioural serializer that preloads bit0 when enabled from inactive and
//   then shifts one bit per cycle; it can be told to raise ser_done early.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] p_data;
    logic       dv1, dv2, par_en, par_typ;
    logic [1:0] sen, sdone, sdata, early;
    logic [7:0] spd0, spd1;
    logic [1:0] tx, rdy, busy, err;
    logic [2:0] sidx [2];
    logic [1:0] sact;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data), .DATA_VALID(dv1),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .ser_done(sdone[0]), .ser_data(sdata[0]),
        .ser_en(sen[0]), .ser_p_data(spd0), .TX_OUT(tx[0]), .TX_READY(rdy[0]),
        .BUSY(busy[0]), .SEQ_ERR(err[0])
    );

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data), .DATA_VALID(dv2),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .ser_done(sdone[1]), .ser_data(sdata[1]),
        .ser_en(sen[1]), .ser_p_data(spd1), .TX_OUT(tx[1]), .TX_READY(rdy[1]),
        .BUSY(busy[1]), .SEQ_ERR(err[1])
    );

    // Serializer stubs.
    assign sdata[0] = spd0[sidx[0]];
    assign sdata[1] = spd1[sidx[1]];
    assign sdone[0] = sact[0] & (early[0] ? (sidx[0] >= 3'd6) : (sidx[0] == 3'd7));
    assign sdone[1] = sact[1] & (early[1] ? (sidx[1] >= 3'd6) : (sidx[1] == 3'd7));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 2; k++) begin
                sact[k] <= 1'b0;
                sidx[k] <= 3'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sen[k] && !sact[k]) begin
                    sact[k] <= 1'b1;
                    sidx[k] <= 3'd0;
                end else if (sact[k]) begin
                    if (sidx[k] == 3'd7) sact[k] <= 1'b0;
                    sidx[k] <= sidx[k] + 3'd1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the chosen DUT idle. exp[i] is TX_OUT in frame
    // cycle i; ser_en is expected high for cycles 0..sen_hi.
    task automatic frame(input string tag, input int w, input logic [7:0] d,
                         input logic pe, input logic pt, input int len,
                         input logic [11:0] exp, input int sen_hi, input int exp_err);
        int errs = 0;
        p_data = d; par_en = pe; par_typ = pt;
        if (w == 0) dv1 = 1'b1; else dv2 = 1'b1;
        @(negedge CLK);
        // Inputs change right after accept; the frame must not notice.
        dv1 = 1'b0; dv2 = 1'b0; par_en = ~pe; par_typ = ~pt; p_data = ~d;
        for (int i = 0; i < len; i++) begin
            chk({tag, "_tx"},   32'(tx[w]),   32'(exp[i]));
            chk({tag, "_busy"}, 32'(busy[w]), 32'd1);
            chk({tag, "_rdy"},  32'(rdy[w]),  32'(i == len - 1));
            chk({tag, "_sen"},  32'(sen[w]),  32'(i <= sen_hi));
            if (i == 1) chk({tag, "_spd"}, 32'(w == 0 ? spd0 : spd1), 32'(d));
            errs += int'(err[w]);
            @(negedge CLK);
        end
        chk({tag, "_idle_tx"},   32'(tx[w]),   32'd1);
        chk({tag, "_idle_busy"}, 32'(busy[w]), 32'd0);
        chk({tag, "_idle_rdy"},  32'(rdy[w]),  32'd1);
        errs += int'(err[w]);
        chk({tag, "_seq_err"}, 32'(errs), 32'(exp_err));
    endtask

    initial begin
        RST = 1'b1; p_data = 8'h00; dv1 = 1'b0; dv2 = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; early = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_tx",   32'(tx),   32'h3);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rdy",  32'(rdy),  32'h3);
        chk("rst_sen",  32'(sen),  32'h0);
        chk("rst_err",  32'(err),  32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // A5 without parity: 0,1,0,1,0,0,1,0,1,1
        frame("t1_a5", 0, 8'hA5, 1'b0, 1'b0, 10, 12'b0011_0100_1010, 7, 0);
        // 03 with even parity (bit 0) then odd parity (bit 1), 11 cycles
        frame("t2_even", 0, 8'h03, 1'b1, 1'b0, 11, 12'b0100_0000_0110, 7, 0);
        frame("t2_odd",  0, 8'h03, 1'b1, 1'b1, 11, 12'b0110_0000_0110, 7, 0);

        // Back-to-back 55 then AA with DATA_VALID held: no idle gap.
        p_data = 8'h55; par_en = 1'b0; dv1 = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            chk("t3_f1_tx",  32'(tx[0]),  32'((10'b1010101010 >> i) & 1));
            chk("t3_f1_rdy", 32'(rdy[0]), 32'(i == 9));
            if (i == 9) p_data = 8'hAA;
            @(negedge CLK);
        end
        for (int i = 0; i < 10; i++) begin
            chk("t3_f2_tx",   32'(tx[0]),   32'((10'b1101010100 >> i) & 1));
            chk("t3_f2_busy", 32'(busy[0]), 32'd1);
            if (i == 0) dv1 = 1'b0;
            @(negedge CLK);
        end
        chk("t3_idle_tx",   32'(tx[0]),   32'd1);
        chk("t3_idle_busy", 32'(busy[0]), 32'd0);

        // Two stop bits on u_dut2: low once, then high for 10 cycles.
        frame("t4_ff", 1, 8'hFF, 1'b0, 1'b0, 11, 12'b0111_1111_1110, 7, 0);

        // Serializer finishes one bit early: one SEQ_ERR pulse, length unchanged.
        early[0] = 1'b1;
        frame("t5_early", 0, 8'h3C, 1'b0, 1'b0, 10, 12'b0010_0111_1000, 6, 1);
        early[0] = 1'b0;

        // Reset during the 4th data bit, then a clean 81 frame.
        p_data = 8'h00; par_en = 1'b0; dv1 = 1'b1;
        @(negedge CLK);
        dv1 = 1'b0;
        repeat (4) @(negedge CLK);
        chk("t6_pre_tx",   32'(tx[0]),   32'd0);
        chk("t6_pre_busy", 32'(busy[0]), 32'd1);
        RST = 1'b1;
        #1;
        chk("t6_rst_tx",   32'(tx[0]),   32'd1);
        chk("t6_rst_busy", 32'(busy[0]), 32'd0);
        chk("t6_rst_sen",  32'(sen[0]),  32'd0);
        chk("t6_rst_rdy",  32'(rdy[0]),  32'd1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        frame("t6_81", 0, 8'h81, 1'b0, 1'b0, 10, 12'b0011_0000_0010, 7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
